// File: rtl/wash_isa_pkg.sv
// Instruction set definitions for the washing register machine.
// Instruction word layout: imm[31:16], reg[15:8], op[7:0].
// Also holds the factory program (clean / rinse / dry) that bank 0 of the
// program store starts out with, plus the loader state encoding.
package wash_isa_pkg;

  localparam logic [7:0] op_halt = 8'h00;
  localparam logic [7:0] op_ldi  = 8'h10;
  localparam logic [7:0] op_out  = 8'h11;
  localparam logic [7:0] op_wait = 8'h12;
  localparam logic [7:0] op_dec  = 8'h20;
  localparam logic [7:0] op_add  = 8'h21;
  localparam logic [7:0] op_jmp  = 8'h31;
  localparam logic [7:0] op_jnz  = 8'h32;

  localparam int op_lsb  = 0;
  localparam int reg_lsb = 8;
  localparam int imm_lsb = 16;

  typedef enum logic [1:0] {
    ld_idle  = 2'd0,
    ld_load  = 2'd1,
    ld_check = 2'd2
  } ld_state_t;

  function automatic logic [31:0] mk_instr(input logic [15:0] imm,
                                           input logic [7:0] r,
                                           input logic [7:0] op);
    return {imm, r, op};
  endfunction

  // Factory program: fill, wash, three rinse passes, spin dry, stop.
  // Output word bits: 1=fill valve, 2=drum motor, 4=rinse pump, 8=spin.
  function automatic logic [31:0] default_prog(input int i);
    logic [31:0] w;
    case (i)
      0:       w = mk_instr(16'd1,   8'd0, op_out);
      1:       w = mk_instr(16'd40,  8'd0, op_wait);
      2:       w = mk_instr(16'd2,   8'd0, op_out);
      3:       w = mk_instr(16'd100, 8'd0, op_wait);
      4:       w = mk_instr(16'd3,   8'd1, op_ldi);
      5:       w = mk_instr(16'd4,   8'd0, op_out);
      6:       w = mk_instr(16'd50,  8'd0, op_wait);
      7:       w = mk_instr(16'd0,   8'd1, op_dec);
      8:       w = mk_instr(16'd5,   8'd1, op_jnz);
      9:       w = mk_instr(16'd8,   8'd0, op_out);
      10:      w = mk_instr(16'd200, 8'd0, op_wait);
      11:      w = mk_instr(16'd0,   8'd0, op_out);
      default: w = mk_instr(16'd0,   8'd0, op_halt);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/prog_bank_store_loader.sv
// prog_loader: byte-serial program loader.
// Assembles little-endian bytes into instruction words, writes each complete
// word into the selected bank, and verifies a trailing checksum byte.
// Ports: clk/rst_n; run (aborts/forbids loads); ld_* service port;
//        wr_en/wr_bank/wr_addr/wr_data memory write; ok_set/ok_clr/ok_bank
//        update the bank-valid flags held in the top.
module prog_loader
  import wash_isa_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 32,
  parameter int NUM_BANKS   = 4,
  parameter int BANK_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   ld_start,
  input  logic [BANK_W-1:0]      ld_bank,
  input  logic                   ld_valid,
  input  logic [7:0]             ld_data,
  output logic                   ld_ready,
  output logic                   ld_done,
  output logic                   ld_err,
  output logic                   wr_en,
  output logic [BANK_W-1:0]      wr_bank,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   ok_set,
  output logic                   ok_clr,
  output logic [BANK_W-1:0]      ok_bank
);

  localparam int BPW  = INSTR_WIDTH / 8;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

  ld_state_t              state_q, state_d;
  logic [BANK_W-1:0]      bank_q;
  logic [ADDR_WIDTH-1:0]  waddr_q;
  logic [BC_W-1:0]        bcnt_q;
  logic [7:0]             sum_q;
  logic [INSTR_WIDTH-1:0] word_q, word_asm;
  logic                   done_q, err_q, done_d, err_d;
  logic                   acc, last_byte, last_word;

  // A byte is never taken in the cycle run rises, so an abort loses nothing
  // that was half-accepted.
  assign ld_ready  = (state_q != ld_idle) && !run;
  assign acc       = ld_valid && ld_ready;
  assign last_byte = (bcnt_q == BC_W'(BPW - 1));
  assign last_word = (waddr_q == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    word_asm = word_q;
    word_asm[int'(bcnt_q)*8 +: 8] = ld_data;
  end

  assign wr_data = word_asm;
  assign wr_bank = bank_q;
  assign wr_addr = waddr_q;
  assign ok_bank = ok_set ? bank_q : ld_bank;
  assign ld_done = done_q;
  assign ld_err  = err_q;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    ok_set  = 1'b0;
    ok_clr  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ld_idle: begin
        if (ld_start) begin
          if (int'(ld_bank) >= NUM_BANKS) begin
            err_d = 1'b1;
          end else if (!run) begin
            state_d = ld_load;
            ok_clr  = 1'b1;
          end
        end
      end
      ld_load: begin
        if (run) begin
          state_d = ld_idle;
          err_d   = 1'b1;
        end else if (acc && last_byte) begin
          wr_en = 1'b1;
          if (last_word) state_d = ld_check;
        end
      end
      ld_check: begin
        if (run) begin
          state_d = ld_idle;
          err_d   = 1'b1;
        end else if (acc) begin
          state_d = ld_idle;
          if ((sum_q + ld_data) == 8'h00) begin
            ok_set = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ld_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ld_idle;
      bank_q  <= '0;
      waddr_q <= '0;
      bcnt_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (ok_clr) begin
        bank_q  <= ld_bank;
        waddr_q <= '0;
        bcnt_q  <= '0;
        sum_q   <= '0;
      end else if (state_q == ld_load && acc) begin
        sum_q <= sum_q + ld_data;
        if (last_byte) begin
          bcnt_q  <= '0;
          waddr_q <= waddr_q + 1'b1;
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
      end
    end
  end

  // Word assembly buffer is pure data; its content only matters once the
  // byte count has been cleared by a start.
  always_ff @(posedge clk) begin
    if (state_q == ld_load && acc) word_q <= word_asm;
  end

endmodule

// File: rtl/prog_bank_store.sv
// prog_bank_store: multi-bank, field-loadable program store.
// Ports: clk/rst_n; run freezes bank select and aborts loads; bank_sel picks
//        the bank used for fetch; rd_en/pc fetch request; instr/instr_vld/fault
//        registered fetch response; ld_* byte-serial loader service port.
// Fetches from an invalid bank or beyond DEPTH return op_halt with fault set.
module prog_bank_store
  import wash_isa_pkg::*;
#(
  parameter  int INSTR_WIDTH = 32,
  parameter  int ADDR_WIDTH  = 8,
  parameter  int DEPTH       = 32,
  parameter  int NUM_BANKS   = 4,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [BANK_W-1:0]      bank_sel,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_vld,
  output logic                   fault,
  input  logic                   ld_start,
  input  logic [BANK_W-1:0]      ld_bank,
  input  logic                   ld_valid,
  input  logic [7:0]             ld_data,
  output logic                   ld_ready,
  output logic                   ld_done,
  output logic                   ld_err
);

  localparam int MEM_N = NUM_BANKS * DEPTH;

  logic                   wr_en, ok_set, ok_clr;
  logic [BANK_W-1:0]      wr_bank, ok_bank, active_bank;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [INSTR_WIDTH-1:0] wr_data, rd_word;
  logic [NUM_BANKS-1:0]   bank_ok;
  logic [INSTR_WIDTH-1:0] rd_arr [MEM_N];
  logic                   rd_ok;
  int                     wr_idx, rd_idx;

  prog_loader #(
    .INSTR_WIDTH(INSTR_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH),
    .NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)
  ) u_loader (
    .clk(clk), .rst_n(rst_n), .run(run),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .ok_set(ok_set), .ok_clr(ok_clr), .ok_bank(ok_bank)
  );

  assign wr_idx = int'(wr_bank) * DEPTH + int'(wr_addr);
  assign rd_idx = int'(active_bank) * DEPTH + int'(pc);

  // Program memory is deliberately outside reset: bank 0 gets the factory
  // program only at configuration, so a field reload survives a reset.
  for (genvar g = 0; g < MEM_N; g++) begin : g_mem
    localparam logic [INSTR_WIDTH-1:0] init_w =
      (g < DEPTH) ? INSTR_WIDTH'(default_prog(g)) : '0;
    logic [INSTR_WIDTH-1:0] word = init_w;
    always_ff @(posedge clk) begin
      if (wr_en && wr_idx == g) word <= wr_data;
    end
    assign rd_arr[g] = word;
  end

  // Reads see the pre-write word, giving read-before-write on a collision.
  always_comb begin
    rd_ok   = (int'(pc) < DEPTH) && (int'(active_bank) < NUM_BANKS) &&
              bank_ok[active_bank];
    rd_word = '0;
    if (rd_ok) rd_word = rd_arr[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_vld   <= 1'b0;
      fault       <= 1'b0;
      active_bank <= '0;
      bank_ok     <= NUM_BANKS'(1);
    end else begin
      instr_vld <= rd_en;
      if (rd_en) begin
        instr <= rd_word;
        fault <= !rd_ok;
      end else begin
        fault <= 1'b0;
      end
      if (!run) active_bank <= bank_sel;
      if (ok_clr) bank_ok[ok_bank] <= 1'b0;
      if (ok_set) bank_ok[ok_bank] <= 1'b1;
    end
  end

endmodule
